serial_frame_controller: RTL and testbench
==========================================

Name: serial_frame_controller

Overview:
- Sequences reception of one 11-bit serial frame: start 0, 8 data bits LSB-first, odd parity, stop 1.
- Runs from debounced line data plus a one-cycle bit-sample strobe. Owns the bit counter, frame checks and timeout.
- Delivers each accepted byte through a VALID/ACK holding register to the downstream consumer.
- Replaces the free-running modulo-11 counter with a start-bit-aligned, error-checked sequencer.

Parameters:
- DATA_BITS, 8, data bits per frame; the bench covers only 8.
- PARITY_ODD, 1, 1 selects odd parity and 0 selects even parity.
- TIMEOUT_CYCLES, 2047, maximum CONTROL_CLOCK cycles between strobes inside a frame before the frame is aborted.
- TIMEOUT_WIDTH, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- CONTROL_CLOCK  input  1  sole clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- SAMPLE_STROBE  input  1  one-cycle pulse, one per serial bit; DEBOUNCED_DATA is valid in that cycle.
- DEBOUNCED_DATA  input  1  debounced serial line, idle high.
- DATA_ACK  input  1  consumer accepts PARALLEL_DATA_OUTPUT when high in a cycle where DATA_VALID is high.
- PARALLEL_DATA_OUTPUT  output  8  last accepted byte, held until the next accepted byte.
- DATA_VALID  output  1  a byte is pending for the consumer.
- PARITY_ERROR  output  1  one-cycle pulse when a frame fails the parity check.
- FRAME_ERROR  output  1  one-cycle pulse on a bad stop bit or a timeout.
- OVERRUN  output  1  sticky; a good frame completed while DATA_VALID was high.
- BUSY  output  1  state is not IDLE.

Behaviour:
- Reset values: state IDLE, bit counter 0, timeout counter 0, PARALLEL_DATA_OUTPUT 8'h00, DATA_VALID 0, PARITY_ERROR 0, FRAME_ERROR 0, OVERRUN 0, BUSY 0.
- RESET mid-frame aborts the frame and discards partial data.
- States:
  - IDLE: on SAMPLE_STROBE with DATA=0, go to DATA, clear bit counter and running parity. A strobe with DATA=1 is ignored.
  - DATA: each strobe shifts DATA into shift[7] with a right shift, so LSB-first bytes land in order. XOR DATA into running parity and increment the counter. On the 8th bit (counter==7) go to PARITY.
  - PARITY: on a strobe, parity_ok = (running ^ DATA) == PARITY_ODD. Go to STOP.
  - STOP: on a strobe, evaluate the frame and go to IDLE.
    - DATA=0: pulse FRAME_ERROR; byte discarded.
    - DATA=1 and !parity_ok: pulse PARITY_ERROR; byte discarded.
    - DATA=1 and parity_ok: the byte is good.
    - If both stop and parity are bad, report only FRAME_ERROR.
- Good byte delivery:
  - If DATA_VALID is 0, or DATA_ACK is high in the same cycle: load PARALLEL_DATA_OUTPUT and set DATA_VALID on the next edge. Latency is 1 cycle from the stop strobe.
  - Otherwise: the old byte is kept, the new byte is dropped, and OVERRUN is set.
- Handshake:
  - DATA_VALID clears on DATA_ACK, unless a new byte loads in the same cycle; the load wins and VALID stays 1.
  - DATA_ACK while DATA_VALID is 0 has no effect.
  - OVERRUN clears on the first DATA_ACK with DATA_VALID high.
- Timeout:
  - The counter clears on every strobe and in IDLE, and increments each cycle otherwise.
  - On reaching TIMEOUT_CYCLES in a non-IDLE state: pulse FRAME_ERROR, go to IDLE, discard the byte.
  - A strobe in the same cycle as expiry takes priority: the counter clears and the frame continues.
- Error pulses are exactly one cycle and registered.

Decomposition:
- Package serial_frame_pkg holds:
  - the state encoding (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - the frame constants START_LEVEL=0, STOP_LEVEL=1 and FRAME_BITS=11.
- One natural sub-module, frame_output_buffer: the VALID/ACK holding register plus OVERRUN logic.
- The FSM, counters and shift register stay in the top module.

Test Plan:
- Good frame 0xA5, strobes every 10 cycles: bits 0,1,0,1,0,0,1,0,1,1,1 (parity 1 because 0xA5 has four ones) -> one cycle after the stop strobe, DATA_VALID=1 and PARALLEL_DATA_OUTPUT=8'hA5; no error pulses. DATA_ACK then clears VALID.
- Parity fault: frame 0x3C sent with parity 0 (correct bit is 1) -> one PARITY_ERROR pulse, DATA_VALID stays 0, output unchanged.
- Bad stop: frame 0x00 with parity 1 and stop 0 -> FRAME_ERROR pulse, PARITY_ERROR stays 0, state IDLE, BUSY=0.
- Timeout: start plus 3 data bits, then no strobes -> FRAME_ERROR pulses exactly TIMEOUT_CYCLES=2047 cycles after the last strobe. A following good frame 0x5A is then received correctly.
- Overrun: 0x11 received and not acked, then 0x22 received -> output stays 8'h11 and OVERRUN=1. DATA_ACK clears VALID and OVERRUN. Also: DATA_ACK coinciding with the stop strobe of 0x33 -> output 8'h33, VALID stays 1, OVERRUN=0.
- Reset mid-frame after 5 data bits -> all outputs at reset values; stray strobes with DATA=1 keep IDLE. The next frame 0xFF (parity 1) is delivered correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver: sequencer states and
// fixed frame levels.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam int unsigned FRAME_BITS  = 11;

endpackage

// File: rtl/serial_frame_controller_buffer.sv
// VALID/ACK holding register between the frame sequencer and the consumer,
// with sticky overrun when a good byte arrives and nowhere can take it.
module frame_output_buffer #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 overrun
);

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // An ack in the load cycle frees the slot, so the load wins and VALID stays up.
      if (load && (!valid_q || ack)) begin
        data_q  <= load_data;
        valid_q <= 1'b1;
      end else if (ack && valid_q) begin
        valid_q <= 1'b0;
      end

      if (ack && valid_q) begin
        overrun_q <= 1'b0;
      end else if (load && valid_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/serial_frame_controller.sv
// Start-bit-aligned receiver for one start/data/parity/stop serial frame,
// driven by a bit-sample strobe, with inter-strobe timeout.
module serial_frame_controller
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_BITS      = FRAME_BITS - 3,
  parameter int unsigned PARITY_ODD     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2047,
  parameter int unsigned TIMEOUT_WIDTH  = 11
) (
  input  logic                 CONTROL_CLOCK,
  input  logic                 RESET,
  input  logic                 SAMPLE_STROBE,
  input  logic                 DEBOUNCED_DATA,
  input  logic                 DATA_ACK,
  output logic [DATA_BITS-1:0] PARALLEL_DATA_OUTPUT,
  output logic                 DATA_VALID,
  output logic                 PARITY_ERROR,
  output logic                 FRAME_ERROR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]         LAST_BIT    = CNT_W'(DATA_BITS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST    = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic                     PARITY_WANT = (PARITY_ODD != 0);

  frame_state_t         state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 parity_ok_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  logic timeout_hit;
  logic byte_good;
  logic parity_err_set;
  logic frame_err_set;

  // Expiry only counts when no strobe arrives in the same cycle; a strobe keeps the frame alive.
  assign timeout_hit = (state_q != IDLE) && !SAMPLE_STROBE && (tmo_q == TMO_LAST);

  always_ff @(posedge CONTROL_CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (SAMPLE_STROBE && DEBOUNCED_DATA == START_LEVEL) state_d = DATA;
      DATA:   if (SAMPLE_STROBE && bit_cnt_q == LAST_BIT)         state_d = PARITY;
      PARITY: if (SAMPLE_STROBE)                                  state_d = STOP;
      STOP:   if (SAMPLE_STROBE)                                  state_d = IDLE;
      default:                                                    state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // A bad stop bit masks a parity failure: only one error is reported per frame.
  always_comb begin
    BUSY           = (state_q != IDLE);
    byte_good      = 1'b0;
    parity_err_set = 1'b0;
    frame_err_set  = timeout_hit;
    if (state_q == STOP && SAMPLE_STROBE) begin
      if (DEBOUNCED_DATA != STOP_LEVEL) begin
        frame_err_set = 1'b1;
      end else if (!parity_ok_q) begin
        parity_err_set = 1'b1;
      end else begin
        byte_good = 1'b1;
      end
    end
  end

  always_ff @(posedge CONTROL_CLOCK) begin
    if (RESET) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      parity_ok_q  <= 1'b0;
      tmo_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= parity_err_set;
      frame_err_q  <= frame_err_set;

      if (state_q == IDLE || SAMPLE_STROBE || timeout_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (SAMPLE_STROBE) begin
        unique case (state_q)
          IDLE: begin
            if (DEBOUNCED_DATA == START_LEVEL) begin
              bit_cnt_q <= '0;
              parity_q  <= 1'b0;
            end
          end
          DATA: begin
            shift_q   <= {DEBOUNCED_DATA, shift_q[DATA_BITS-1:1]};
            parity_q  <= parity_q ^ DEBOUNCED_DATA;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          PARITY: begin
            parity_ok_q <= ((parity_q ^ DEBOUNCED_DATA) == PARITY_WANT);
          end
          default: begin
          end
        endcase
      end
    end
  end

  frame_output_buffer #(
    .DATA_BITS(DATA_BITS)
  ) u_buffer (
    .clk       (CONTROL_CLOCK),
    .reset     (RESET),
    .load      (byte_good),
    .load_data (shift_q),
    .ack       (DATA_ACK),
    .data_out  (PARALLEL_DATA_OUTPUT),
    .valid     (DATA_VALID),
    .overrun   (OVERRUN)
  );

  assign PARITY_ERROR = parity_err_q;
  assign FRAME_ERROR  = frame_err_q;

endmodule

// File: tb/tb_serial_frame_controller.sv
// Scoreboard bench for serial_frame_controller: frame-level reference model
// pushes expected events, a negedge monitor pops and compares them.
module tb_serial_frame_controller;

  typedef enum int {EV_BYTE = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    logic        ovr;
    int unsigned cyc;
  } ev_t;

  logic       CONTROL_CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       SAMPLE_STROBE = 1'b0;
  logic       DEBOUNCED_DATA = 1'b1;
  logic       DATA_ACK = 1'b0;
  logic [7:0] PARALLEL_DATA_OUTPUT;
  logic       DATA_VALID, PARITY_ERROR, FRAME_ERROR, OVERRUN, BUSY;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ovr = 1'b0;
  bit         prev_valid = 1'b0;
  bit         prev_ack = 1'b0;

  serial_frame_controller #(
    .DATA_BITS(8),
    .PARITY_ODD(1),
    .TIMEOUT_CYCLES(2047),
    .TIMEOUT_WIDTH(11)
  ) dut (
    .CONTROL_CLOCK        (CONTROL_CLOCK),
    .RESET                (RESET),
    .SAMPLE_STROBE        (SAMPLE_STROBE),
    .DEBOUNCED_DATA       (DEBOUNCED_DATA),
    .DATA_ACK             (DATA_ACK),
    .PARALLEL_DATA_OUTPUT (PARALLEL_DATA_OUTPUT),
    .DATA_VALID           (DATA_VALID),
    .PARITY_ERROR         (PARITY_ERROR),
    .FRAME_ERROR          (FRAME_ERROR),
    .OVERRUN              (OVERRUN),
    .BUSY                 (BUSY)
  );

  always #5 CONTROL_CLOCK = ~CONTROL_CLOCK;
  always @(posedge CONTROL_CLOCK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_ev(input ev_kind_t kind, input logic [7:0] data, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.ovr  = 1'b0;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", cyc, e.cyc);
      if (kind == EV_BYTE && e.kind == EV_BYTE) begin
        check("byte_data", 32'(data), 32'(e.data));
        check("overrun_at_load", 32'(OVERRUN), 32'(e.ovr));
      end
    end
  endtask

  // A delivered byte is a VALID rise, or VALID held through a cycle that carried an ack.
  always @(negedge CONTROL_CLOCK) begin
    if (RESET) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (FRAME_ERROR) observe(EV_FERR, 8'h00);
      if (PARITY_ERROR) observe(EV_PERR, 8'h00);
      if (DATA_VALID && (!prev_valid || prev_ack)) observe(EV_BYTE, PARALLEL_DATA_OUTPUT);
      prev_valid = DATA_VALID;
      prev_ack   = DATA_ACK;
    end
  end

  // Frame-level reference: odd parity means data plus parity bit carry an odd count of ones.
  task automatic model_frame(input logic [7:0] data, input logic par, input logic stop,
                             input logic ack);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    if (!stop) begin
      push_ev(EV_FERR, 8'h00, cyc);
      if (ack && m_valid) begin m_valid = 0; m_ovr = 0; end
    end else if (((ones + int'(par)) % 2) != 1) begin
      push_ev(EV_PERR, 8'h00, cyc);
      if (ack && m_valid) begin m_valid = 0; m_ovr = 0; end
    end else if (!m_valid || ack) begin
      m_valid = 1;
      m_data  = data;
      m_ovr   = 0;
      push_ev(EV_BYTE, data, cyc);
    end else begin
      m_ovr = 1;
    end
  endtask

  function automatic logic odd_par(input logic [7:0] data);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic send_bit(input logic b, input int unsigned gap, input logic ack);
    repeat (gap - 1) begin @(posedge CONTROL_CLOCK); #1; end
    SAMPLE_STROBE = 1'b1;
    DEBOUNCED_DATA = b;
    DATA_ACK = ack;
    @(posedge CONTROL_CLOCK); #1;
    SAMPLE_STROBE = 1'b0;
    DEBOUNCED_DATA = 1'b1;
    DATA_ACK = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int unsigned gap, input logic ack);
    send_bit(1'b0, gap, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], gap, 1'b0);
    send_bit(par, gap, 1'b0);
    send_bit(stop, gap, ack);
    model_frame(data, par, stop, ack);
  endtask

  task automatic do_ack();
    DATA_ACK = 1'b1;
    @(posedge CONTROL_CLOCK); #1;
    DATA_ACK = 1'b0;
    if (m_valid) begin m_valid = 0; m_ovr = 0; end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'h0);
    check({tag, "_valid"}, 32'(DATA_VALID), 32'(m_valid));
    check({tag, "_data"}, 32'(PARALLEL_DATA_OUTPUT), 32'(m_data));
    check({tag, "_overrun"}, 32'(OVERRUN), 32'(m_ovr));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(PARALLEL_DATA_OUTPUT), 32'h0);
    check({tag, "_valid"}, 32'(DATA_VALID), 32'h0);
    check({tag, "_perr"}, 32'(PARITY_ERROR), 32'h0);
    check({tag, "_ferr"}, 32'(FRAME_ERROR), 32'h0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'h0);
    check({tag, "_busy"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    logic [7:0]  d;
    logic        p, s, a;
    int unsigned kind, gap;

    RESET = 1'b1;
    repeat (3) @(posedge CONTROL_CLOCK);
    #1;
    check_reset_values("reset");
    RESET = 1'b0;
    @(posedge CONTROL_CLOCK); #1;

    send_frame(8'hA5, 1'b1, 1'b1, 10, 1'b0);
    check("a5_valid", 32'(DATA_VALID), 32'h1);
    check("a5_data", 32'(PARALLEL_DATA_OUTPUT), 32'hA5);
    do_ack();
    check("a5_ack_valid", 32'(DATA_VALID), 32'h0);

    send_frame(8'h3C, 1'b0, 1'b1, 10, 1'b0);
    check_model("parity_fault");

    send_frame(8'h00, 1'b1, 1'b0, 10, 1'b0);
    check_model("bad_stop");

    send_bit(1'b0, 10, 1'b0);
    send_bit(1'b1, 10, 1'b0);
    send_bit(1'b0, 10, 1'b0);
    send_bit(1'b1, 10, 1'b0);
    check("timeout_busy_mid", 32'(BUSY), 32'h1);
    push_ev(EV_FERR, 8'h00, cyc + 2047);
    repeat (2100) begin @(posedge CONTROL_CLOCK); #1; end
    check_model("timeout");
    send_frame(8'h5A, 1'b1, 1'b1, 10, 1'b0);
    check("after_timeout_data", 32'(PARALLEL_DATA_OUTPUT), 32'h5A);
    do_ack();

    send_frame(8'h11, 1'b1, 1'b1, 10, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 10, 1'b0);
    check("overrun_held_data", 32'(PARALLEL_DATA_OUTPUT), 32'h11);
    check("overrun_set", 32'(OVERRUN), 32'h1);
    do_ack();
    check("overrun_ack_valid", 32'(DATA_VALID), 32'h0);
    check("overrun_ack_clear", 32'(OVERRUN), 32'h0);
    send_frame(8'h44, 1'b0, 1'b1, 10, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 10, 1'b1);
    check("ack_on_stop_data", 32'(PARALLEL_DATA_OUTPUT), 32'h33);
    check("ack_on_stop_valid", 32'(DATA_VALID), 32'h1);
    check("ack_on_stop_overrun", 32'(OVERRUN), 32'h0);
    do_ack();

    send_frame(8'h77, 1'b0, 1'b1, 10, 1'b0);
    send_bit(1'b0, 10, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 10, 1'b0);
    RESET = 1'b1;
    @(posedge CONTROL_CLOCK); #1;
    RESET = 1'b0;
    m_valid = 0; m_data = 8'h00; m_ovr = 0;
    check_reset_values("mid_reset");
    for (int i = 0; i < 3; i++) send_bit(1'b1, 3, 1'b0);
    check("stray_strobe_busy", 32'(BUSY), 32'h0);
    send_frame(8'hFF, 1'b1, 1'b1, 10, 1'b0);
    check("ff_data", 32'(PARALLEL_DATA_OUTPUT), 32'hFF);
    do_ack();

    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 5);
      gap  = $urandom_range(1, 12);
      p    = odd_par(d);
      s    = 1'b1;
      a    = 1'b0;
      if (kind == 0) p = ~p;
      else if (kind == 1) begin s = 1'b0; p = 1'($urandom_range(0, 1)); end
      else a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) send_bit(1'b1, gap, 1'b0);
      send_frame(d, p, s, gap, a);
      check_model("random");
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    repeat (5) begin @(posedge CONTROL_CLOCK); #1; end
    check("pending_events", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
